pipelined_shifter: RTL and testbench
====================================

// Module: pipelined_shifter
// PURPOSE
//  Parametrised, pipelined barrel shifter for the mini CPU execute path. Supports
//  logical left, logical right, arithmetic right and (optionally) rotate right.
//  Uses a valid/ready handshake on input and output, so it can stall under back-pressure.
//  Replaces the single-cycle combinational right shifter in wide or high-frequency builds.
// PARAMETERS
//  WIDTH   32  data width; power of two, >= 8
//  STAGES  2   pipeline register levels, 1..$clog2(WIDTH); also the latency in cycles
//  TAG_W   4   width of the sideband tag carried alongside each operation
// PORTS
//  clk        in   1        clock; all logic is on the rising edge
//  rst        in   1        synchronous reset, active-high
//  in_valid   in   1        input operation valid
//  in_ready   out  1        block can accept an operation this cycle
//  in_op      in   2        00 SLL, 01 SRL, 10 SRA, 11 ROR
//  in_data    in   WIDTH    operand A
//  in_amt     in   WIDTH    shift amount B, full width
//  in_tag     in   TAG_W    passed through unchanged
//  out_valid  out  1        result valid
//  out_ready  in   1        consumer accepts the result
//  out_data   out  WIDTH    shifted result
//  out_tag    out  TAG_W    tag of the result
//  out_zero   out  1        out_data == 0
// BEHAVIOUR
//  - Transfer rules: input transfers when in_valid & in_ready; output transfers when out_valid & out_ready.
//  - Datapath: L = $clog2(WIDTH) mux levels. Level i shifts by 2^i when amt[i] = 1.
//    Levels are split evenly over STAGES register levels; the first stages take the extra levels.
//  - Per-stage register: valid bit, op, partial data, remaining amt bits, tag.
//    Stage k loads when it is empty or stage k+1 is loading/consuming; for the last stage, out_ready stands in for stage k+1.
//  - in_ready  = ~v[0] | advance[0]  (combinational from out_ready through the pipeline).
//  - Throughput: one op per cycle while out_ready = 1.
//  - Latency: exactly STAGES cycles from input transfer to out_valid.
//  - Order: results leave in acceptance order; there is no bypass.
//  - While out_valid & ~out_ready: out_data, out_tag and out_zero hold stable.
//  - Amounts with any bit >= L set, i.e. amt >= WIDTH:
//    - SLL, SRL give 0.
//    - SRA gives {WIDTH{A[WIDTH-1]}}.
//    - ROR uses amt mod WIDTH.
//    - The out-of-range decision is made in stage 0 and carried as a flag.
//  - SRA fill bit is A[WIDTH-1] as captured at input; it is carried through all stages.
//  - amt = 0 gives out_data = A for every op.
//  - Reset: all valid bits 0; out_valid = 0, out_data = 0, out_tag = 0, out_zero = 0.
//    in_ready = 1 in the cycle after reset is released.
//  - Reset mid-operation: in-flight ops are discarded, with no partial output.
//    in_valid is ignored while rst = 1.
//  - Simultaneous output drain and input accept in the same cycle is legal with a full pipe.
// CONFIGURATION
//  - Macro SHIFTER_ROTATE_EN.
//  - Defined: op 11 performs rotate right as described above.
//  - Undefined: the rotate muxes are not built and op 11 executes as SRL; all timing is identical.
// STRUCTURE
//  - Package shifter_pkg holds:
//    - localparams OP_SLL=2'b00, OP_SRL=2'b01, OP_SRA=2'b10, OP_ROR=2'b11;
//    - typedef shift_op_t;
//    - function levels_per_stage(WIDTH, STAGES).
//  - Sub-module shift_level: one combinational mux level with parameters WIDTH and DIST (= 2^i).
//    - Inputs: op, fill, en, data.
//    - Output: data shifted or rotated by DIST when en = 1.
//  - pipelined_shifter instantiates L shift_level instances and STAGES register levels.
// TESTING (WIDTH=32, STAGES=2, unless noted)
//  - Basic ops, amt 4 on A=32'h8000_0000, checked 2 cycles after accept:
//    - SRA -> 32'hF800_0000;
//    - SRL -> 32'h0800_0000;
//    - SLL -> 0 with out_zero = 1.
//  - Range limits:
//    - SLL A=1, amt=31 -> 32'h8000_0000.
//    - SLL amt=32 -> 0.
//    - SRA A=32'h8000_0001, amt=100 -> 32'hFFFF_FFFF.
//  - Rotate:
//    - ROR A=32'h1234_5678, amt=8 -> 32'h7812_3456.
//    - Same with amt=40 gives the same result.
//    - With SHIFTER_ROTATE_EN undefined -> 32'h0012_3456.
//  - Back-pressure: out_ready=0 while 3 ops with tags 1,2,3 are offered back-to-back.
//    - Exactly 2 ops are accepted, then in_ready=0.
//    - out_data stays stable.
//    - Raising out_ready drains tags 1,2,3 in order on consecutive cycles.
//  - Streaming: 50 random ops with out_ready=1 throughout.
//    - in_ready stays 1 and one result comes out per cycle.
//    - Every result matches the reference model. Repeat for STAGES=1 and STAGES=5.
//  - Reset during flight: rst=1 for 1 cycle with 2 valid ops in flight.
//    - Next cycle out_valid=0 and out_data=0.
//    - No ghost result ever appears.

Source files
------------

// File: rtl/shifter_pkg.sv
// Shared types and level-split helpers for the pipelined barrel shifter.
// Optional rotate datapath is enabled by defining SHIFTER_ROTATE_EN.
package shifter_pkg;

  typedef logic [1:0] shift_op_t;

  localparam shift_op_t OP_SLL = 2'b00;
  localparam shift_op_t OP_SRL = 2'b01;
  localparam shift_op_t OP_SRA = 2'b10;
  localparam shift_op_t OP_ROR = 2'b11;

  function automatic int levels_per_stage(int width, int stages);
    return $clog2(width) / stages;
  endfunction

  // Leading stages absorb the remainder levels.
  function automatic int stage_levels(int width, int stages, int k);
    int l;
    l = $clog2(width);
    return levels_per_stage(width, stages) + ((k < (l % stages)) ? 1 : 0);
  endfunction

  function automatic int stage_first(int width, int stages, int k);
    int f;
    f = 0;
    for (int j = 0; j < k; j++) f += stage_levels(width, stages, j);
    return f;
  endfunction

endpackage

// File: rtl/pipelined_shifter_level.sv
// One combinational barrel-shifter mux level shifting by DIST.
// Rotate mux only exists when SHIFTER_ROTATE_EN is defined.
module shift_level
  import shifter_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int DIST  = 1
) (
  input  logic [1:0]       op,
  input  logic             fill,
  input  logic             en,
  input  logic [WIDTH-1:0] data_i,
  output logic [WIDTH-1:0] data_o
);

  always_comb begin
    data_o = data_i;
    if (en) begin
      case (op)
        OP_SLL: data_o = data_i << DIST;
        OP_SRA: data_o = {{DIST{fill}}, data_i[WIDTH-1:DIST]};
`ifdef SHIFTER_ROTATE_EN
        OP_ROR: data_o = {data_i[DIST-1:0], data_i[WIDTH-1:DIST]};
`endif
        default: data_o = data_i >> DIST;
      endcase
    end
  end

endmodule

// File: rtl/pipelined_shifter.sv
// Pipelined barrel shifter with valid/ready on both sides.
// Define SHIFTER_ROTATE_EN to build rotate-right for op 11.
module pipelined_shifter
  import shifter_pkg::*;
#(
  parameter int WIDTH  = 32,
  parameter int STAGES = 2,
  parameter int TAG_W  = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [1:0]       in_op,
  input  logic [WIDTH-1:0] in_data,
  input  logic [WIDTH-1:0] in_amt,
  input  logic [TAG_W-1:0] in_tag,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  output logic [TAG_W-1:0] out_tag,
  output logic             out_zero
);

  localparam int L  = $clog2(WIDTH);
  localparam int LS = STAGES - 1;

  logic             v_q    [STAGES];
  logic             v_d    [STAGES];
  logic [1:0]       op_q   [STAGES];
  logic [1:0]       op_d   [STAGES];
  logic             fill_q [STAGES];
  logic             fill_d [STAGES];
  logic             oor_q  [STAGES];
  logic             oor_d  [STAGES];
  logic [L-1:0]     amt_q  [STAGES];
  logic [L-1:0]     amt_d  [STAGES];
  logic [WIDTH-1:0] data_q [STAGES];
  logic [WIDTH-1:0] data_d [STAGES];
  logic [TAG_W-1:0] tag_q  [STAGES];
  logic [TAG_W-1:0] tag_d  [STAGES];
  logic             zero_q;
  logic             zero_d;

  logic             s_v    [STAGES];
  logic [1:0]       s_op   [STAGES];
  logic             s_fill [STAGES];
  logic             s_oor  [STAGES];
  logic [L-1:0]     s_amt  [STAGES];
  logic [WIDTH-1:0] s_data [STAGES];
  logic [TAG_W-1:0] s_tag  [STAGES];
  logic [WIDTH-1:0] shifted [STAGES];
  logic             load   [STAGES+1];
  logic [WIDTH-1:0] last_data;

  always_comb begin
    s_v[0]    = in_valid;
    s_op[0]   = in_op;
    s_fill[0] = in_data[WIDTH-1];
    s_oor[0]  = |(in_amt >> L);
    s_amt[0]  = in_amt[L-1:0];
    s_data[0] = in_data;
    s_tag[0]  = in_tag;
    for (int k = 1; k < STAGES; k++) begin
      s_v[k]    = v_q[k-1];
      s_op[k]   = op_q[k-1];
      s_fill[k] = fill_q[k-1];
      s_oor[k]  = oor_q[k-1];
      s_amt[k]  = amt_q[k-1];
      s_data[k] = data_q[k-1];
      s_tag[k]  = tag_q[k-1];
    end
  end

  for (genvar k = 0; k < STAGES; k++) begin : g_stage
    localparam int N = stage_levels(WIDTH, STAGES, k);
    localparam int F = stage_first(WIDTH, STAGES, k);
    logic [WIDTH-1:0] chain [N+1];
    assign chain[0] = s_data[k];
    for (genvar j = 0; j < N; j++) begin : g_lvl
      shift_level #(
        .WIDTH (WIDTH),
        .DIST  (1 << (F + j))
      ) u_lvl (
        .op     (s_op[k]),
        .fill   (s_fill[k]),
        .en     (s_amt[k][F+j]),
        .data_i (chain[j]),
        .data_o (chain[j+1])
      );
    end
    assign shifted[k] = chain[N];
  end

  // Out-of-range amounts override the mux result; rotate keeps amt mod WIDTH.
  always_comb begin
    last_data = shifted[LS];
    if (s_oor[LS]) begin
      if (s_op[LS] == OP_SRA) begin
        last_data = {WIDTH{s_fill[LS]}};
      end else begin
`ifdef SHIFTER_ROTATE_EN
        if (s_op[LS] != OP_ROR) last_data = '0;
`else
        last_data = '0;
`endif
      end
    end
  end

  always_comb begin
    load[STAGES] = out_ready;
    for (int k = STAGES - 1; k >= 0; k--) begin
      load[k] = ~v_q[k] | load[k+1];
    end
    for (int k = 0; k < STAGES; k++) begin
      v_d[k]    = load[k] ? s_v[k] : v_q[k];
      op_d[k]   = op_q[k];
      fill_d[k] = fill_q[k];
      oor_d[k]  = oor_q[k];
      amt_d[k]  = amt_q[k];
      data_d[k] = data_q[k];
      tag_d[k]  = tag_q[k];
      if (load[k] && s_v[k]) begin
        op_d[k]   = s_op[k];
        fill_d[k] = s_fill[k];
        oor_d[k]  = s_oor[k];
        amt_d[k]  = s_amt[k];
        data_d[k] = shifted[k];
        tag_d[k]  = s_tag[k];
      end
    end
    zero_d = zero_q;
    if (load[LS] && s_v[LS]) begin
      data_d[LS] = last_data;
      zero_d     = (last_data == '0);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int k = 0; k < STAGES; k++) begin
        v_q[k]    <= 1'b0;
        op_q[k]   <= '0;
        fill_q[k] <= 1'b0;
        oor_q[k]  <= 1'b0;
        amt_q[k]  <= '0;
        data_q[k] <= '0;
        tag_q[k]  <= '0;
      end
      zero_q <= 1'b0;
    end else begin
      for (int k = 0; k < STAGES; k++) begin
        v_q[k]    <= v_d[k];
        op_q[k]   <= op_d[k];
        fill_q[k] <= fill_d[k];
        oor_q[k]  <= oor_d[k];
        amt_q[k]  <= amt_d[k];
        data_q[k] <= data_d[k];
        tag_q[k]  <= tag_d[k];
      end
      zero_q <= zero_d;
    end
  end

  assign in_ready  = load[0];
  assign out_valid = v_q[LS];
  assign out_data  = data_q[LS];
  assign out_tag   = tag_q[LS];
  assign out_zero  = zero_q;

endmodule

// File: tb/tb_pipelined_shifter.sv
// Scoreboard bench for pipelined_shifter (STAGES 2, plus 1 and 5 in streaming).
// Rotate expectations follow SHIFTER_ROTATE_EN.
module tb_pipelined_shifter;

`ifdef SHIFTER_ROTATE_EN
  localparam bit ROT = 1'b1;
`else
  localparam bit ROT = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        in_valid = 1'b0;
  logic        x_valid = 1'b0;
  logic        out_ready = 1'b1;
  logic        x_ready = 1'b1;
  logic [1:0]  in_op = 2'b00;
  logic [31:0] in_data = '0;
  logic [31:0] in_amt = '0;
  logic [3:0]  in_tag = '0;

  logic        in_ready, out_valid, out_zero;
  logic [31:0] out_data;
  logic [3:0]  out_tag;
  logic        x1_in_ready, x1_out_valid, x1_out_zero;
  logic [31:0] x1_out_data;
  logic [3:0]  x1_out_tag;
  logic        x5_in_ready, x5_out_valid, x5_out_zero;
  logic [31:0] x5_out_data;
  logic [3:0]  x5_out_tag;

  always #5 clk = ~clk;

  pipelined_shifter #(.WIDTH(32), .STAGES(2), .TAG_W(4)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_op(in_op), .in_data(in_data), .in_amt(in_amt), .in_tag(in_tag),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_data(out_data), .out_tag(out_tag), .out_zero(out_zero)
  );

  pipelined_shifter #(.WIDTH(32), .STAGES(1), .TAG_W(4)) dut1 (
    .clk(clk), .rst(rst),
    .in_valid(x_valid), .in_ready(x1_in_ready),
    .in_op(in_op), .in_data(in_data), .in_amt(in_amt), .in_tag(in_tag),
    .out_valid(x1_out_valid), .out_ready(x_ready),
    .out_data(x1_out_data), .out_tag(x1_out_tag), .out_zero(x1_out_zero)
  );

  pipelined_shifter #(.WIDTH(32), .STAGES(5), .TAG_W(4)) dut5 (
    .clk(clk), .rst(rst),
    .in_valid(x_valid), .in_ready(x5_in_ready),
    .in_op(in_op), .in_data(in_data), .in_amt(in_amt), .in_tag(in_tag),
    .out_valid(x5_out_valid), .out_ready(x_ready),
    .out_data(x5_out_data), .out_tag(x5_out_tag), .out_zero(x5_out_zero)
  );

  typedef struct packed {
    logic [31:0] data;
    logic [3:0]  tag;
  } exp_t;

  exp_t        sb[$];
  logic [31:0] q1[$];
  logic [31:0] q5[$];
  int          checks = 0;
  int          failures = 0;

  function automatic logic [31:0] ref_shift(logic [1:0] op, logic [31:0] a,
                                            logic [31:0] amt);
    int r;
    bit big;
    r = int'(amt[4:0]);
    big = (amt >= 32);
    if (op == 2'b00) return big ? 32'h0 : (a << r);
    if (op == 2'b10) return big ? {32{a[31]}} : 32'($signed(a) >>> r);
    if (op == 2'b11 && ROT) begin
      if (r == 0) return a;
      return (a >> r) | (a << (32 - r));
    end
    return big ? 32'h0 : (a >> r);
  endfunction

  task automatic test_reset();
    rst = 1'b1;
    in_valid = 1'b0;
    x_valid = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    #1;
    checks++;
    if (out_valid !== 1'b0) begin
      failures++; $display("FAIL reset_out_valid got=%b want=0", out_valid);
    end
    checks++;
    if (out_data !== 32'h0) begin
      failures++; $display("FAIL reset_out_data got=%h want=0", out_data);
    end
    checks++;
    if (out_tag !== 4'h0) begin
      failures++; $display("FAIL reset_out_tag got=%h want=0", out_tag);
    end
    checks++;
    if (out_zero !== 1'b0) begin
      failures++; $display("FAIL reset_out_zero got=%b want=0", out_zero);
    end
    checks++;
    if (in_ready !== 1'b1) begin
      failures++; $display("FAIL reset_in_ready got=%b want=1", in_ready);
    end
  endtask

  task automatic test_ops();
    logic [1:0]  t_op  [14];
    logic [31:0] t_a   [14];
    logic [31:0] t_amt [14];
    logic [31:0] t_exp [14];
    t_op  = '{2'b10, 2'b01, 2'b00, 2'b00, 2'b00, 2'b10, 2'b01,
              2'b10, 2'b11, 2'b11, 2'b00, 2'b01, 2'b10, 2'b11};
    t_a   = '{32'h8000_0000, 32'h8000_0000, 32'h8000_0000, 32'h0000_0001,
              32'hFFFF_FFFF, 32'h8000_0001, 32'hFFFF_FFFF, 32'h7FFF_FFFF,
              32'h1234_5678, 32'h1234_5678, 32'hA5A5_0F0F, 32'hA5A5_0F0F,
              32'hA5A5_0F0F, 32'hA5A5_0F0F};
    t_amt = '{32'd4, 32'd4, 32'd4, 32'd31, 32'd32, 32'd100, 32'd33,
              32'd100, 32'd8, 32'd40, 32'd0, 32'd0, 32'd0, 32'd0};
    t_exp = '{32'hF800_0000, 32'h0800_0000, 32'h0, 32'h8000_0000,
              32'h0, 32'hFFFF_FFFF, 32'h0, 32'h0,
              32'h7812_3456, 32'h7812_3456, 32'hA5A5_0F0F, 32'hA5A5_0F0F,
              32'hA5A5_0F0F, 32'hA5A5_0F0F};
    if (!ROT) begin
      t_exp[8] = 32'h0012_3456;
      t_exp[9] = 32'h0;
    end
    out_ready = 1'b1;
    for (int i = 0; i < 14; i++) begin
      @(negedge clk);
      in_valid = 1'b1;
      in_op = t_op[i];
      in_data = t_a[i];
      in_amt = t_amt[i];
      in_tag = i[3:0];
      #1;
      checks++;
      if (in_ready !== 1'b1) begin
        failures++; $display("FAIL ops_in_ready[%0d] got=%b want=1", i, in_ready);
      end
      @(posedge clk);
      #1;
      in_valid = 1'b0;
      checks++;
      if (out_valid !== 1'b0) begin
        failures++; $display("FAIL ops_early_valid[%0d] got=%b want=0", i, out_valid);
      end
      @(posedge clk);
      #1;
      checks++;
      if (out_valid !== 1'b1) begin
        failures++; $display("FAIL ops_latency[%0d] got=%b want=1", i, out_valid);
      end
      checks++;
      if (out_data !== t_exp[i]) begin
        failures++;
        $display("FAIL ops_data[%0d] got=%h want=%h", i, out_data, t_exp[i]);
      end
      checks++;
      if (out_zero !== (t_exp[i] == 32'h0)) begin
        failures++; $display("FAIL ops_zero[%0d] got=%b", i, out_zero);
      end
      checks++;
      if (out_tag !== i[3:0]) begin
        failures++; $display("FAIL ops_tag[%0d] got=%h want=%h", i, out_tag, i[3:0]);
      end
    end
    @(negedge clk);
  endtask

  task automatic test_back_to_back();
    int idx;
    int npop;
    int first;
    bit acc;
    bit held_set;
    logic [31:0] held;
    exp_t e;
    idx = 0;
    held_set = 1'b0;
    held = '0;
    for (int c = 0; c < 6; c++) begin
      @(negedge clk);
      out_ready = 1'b0;
      in_valid = (idx < 3);
      in_op = 2'b01;
      in_data = 32'hF0F0_0000 + 32'(idx);
      in_amt = 32'(idx + 1);
      in_tag = 4'(idx + 1);
      #1;
      acc = in_valid && in_ready;
      if (acc) begin
        e.data = ref_shift(in_op, in_data, in_amt);
        e.tag = in_tag;
        sb.push_back(e);
      end
      if (out_valid) begin
        if (held_set) begin
          checks++;
          if (out_data !== held) begin
            failures++; $display("FAIL bp_stable got=%h want=%h", out_data, held);
          end
        end else begin
          held = out_data;
          held_set = 1'b1;
        end
      end
      @(posedge clk);
      if (acc) idx++;
    end
    checks++;
    if (idx != 2) begin
      failures++; $display("FAIL bp_accepted got=%0d want=2", idx);
    end
    checks++;
    if (in_ready !== 1'b0) begin
      failures++; $display("FAIL bp_in_ready got=%b want=0", in_ready);
    end
    checks++;
    if (held_set != 1'b1) begin
      failures++; $display("FAIL bp_no_output got=%b want=1", held_set);
    end
    npop = 0;
    first = -1;
    for (int c = 0; c < 10 && npop < 3; c++) begin
      @(negedge clk);
      out_ready = 1'b1;
      in_valid = (idx < 3);
      in_op = 2'b01;
      in_data = 32'hF0F0_0000 + 32'(idx);
      in_amt = 32'(idx + 1);
      in_tag = 4'(idx + 1);
      #1;
      acc = in_valid && in_ready;
      if (acc) begin
        e.data = ref_shift(in_op, in_data, in_amt);
        e.tag = in_tag;
        sb.push_back(e);
      end
      if (out_valid) begin
        checks++;
        if (sb.size() == 0) begin
          failures++; $display("FAIL bp_ghost tag=%h", out_tag);
        end else begin
          e = sb.pop_front();
          if (out_tag !== 4'(npop + 1) || out_data !== e.data) begin
            failures++;
            $display("FAIL bp_drain[%0d] got=%h/%h want=%h/%h",
                     npop, out_tag, out_data, 4'(npop + 1), e.data);
          end
        end
        if (npop == 0) begin
          first = c;
        end else begin
          checks++;
          if (c != first + npop) begin
            failures++; $display("FAIL bp_gap cycle=%0d want=%0d", c, first + npop);
          end
        end
        npop++;
      end
      @(posedge clk);
      if (acc) idx++;
    end
    @(negedge clk);
    in_valid = 1'b0;
    checks++;
    if (npop != 3) begin
      failures++; $display("FAIL bp_drain_count got=%0d want=3", npop);
    end
    sb.delete();
  endtask

  task automatic test_stream();
    int n_sent, n_out, first_c, last_c;
    int sel;
    exp_t e;
    logic [31:0] d;
    n_sent = 0;
    n_out = 0;
    first_c = -1;
    last_c = -1;
    out_ready = 1'b1;
    for (int c = 0; c < 70; c++) begin
      @(negedge clk);
      if (n_sent < 50) begin
        in_valid = 1'b1;
        x_valid = 1'b1;
        in_op = 2'($urandom_range(0, 3));
        in_data = $urandom;
        sel = $urandom_range(0, 3);
        in_amt = (sel == 0) ? $urandom : $urandom_range(0, 33);
        in_tag = 4'($urandom_range(0, 15));
      end else begin
        in_valid = 1'b0;
        x_valid = 1'b0;
      end
      #1;
      if (in_valid) begin
        checks++;
        if ({in_ready, x1_in_ready, x5_in_ready} !== 3'b111) begin
          failures++;
          $display("FAIL st_in_ready c=%0d got=%b%b%b want=111",
                   c, in_ready, x1_in_ready, x5_in_ready);
        end
        d = ref_shift(in_op, in_data, in_amt);
        e.data = d;
        e.tag = in_tag;
        sb.push_back(e);
        q1.push_back(d);
        q5.push_back(d);
        n_sent++;
      end
      if (out_valid) begin
        checks++;
        if (sb.size() == 0) begin
          failures++; $display("FAIL st_ghost c=%0d data=%h", c, out_data);
        end else begin
          e = sb.pop_front();
          if (out_data !== e.data || out_tag !== e.tag ||
              out_zero !== (e.data == 32'h0)) begin
            failures++;
            $display("FAIL st_result c=%0d got=%h/%h want=%h/%h",
                     c, out_data, out_tag, e.data, e.tag);
          end
        end
        n_out++;
        if (first_c < 0) first_c = c;
        last_c = c;
      end
      if (x1_out_valid) begin
        checks++;
        if (q1.size() == 0) begin
          failures++; $display("FAIL st1_ghost c=%0d", c);
        end else begin
          d = q1.pop_front();
          if (x1_out_data !== d) begin
            failures++; $display("FAIL st1_result got=%h want=%h", x1_out_data, d);
          end
        end
      end
      if (x5_out_valid) begin
        checks++;
        if (q5.size() == 0) begin
          failures++; $display("FAIL st5_ghost c=%0d", c);
        end else begin
          d = q5.pop_front();
          if (x5_out_data !== d) begin
            failures++; $display("FAIL st5_result got=%h want=%h", x5_out_data, d);
          end
        end
      end
      @(posedge clk);
    end
    checks++;
    if (n_out != 50) begin
      failures++; $display("FAIL st_count got=%0d want=50", n_out);
    end
    checks++;
    if (first_c != 2 || last_c - first_c != 49) begin
      failures++; $display("FAIL st_rate first=%0d last=%0d want=2/51", first_c, last_c);
    end
    checks++;
    if (sb.size() != 0 || q1.size() != 0 || q5.size() != 0) begin
      failures++;
      $display("FAIL st_leftover got=%0d/%0d/%0d want=0", sb.size(), q1.size(), q5.size());
    end
    sb.delete();
    q1.delete();
    q5.delete();
  endtask

  task automatic test_reset_flight();
    bit ghost;
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      out_ready = 1'b0;
      in_valid = 1'b1;
      x_valid = 1'b1;
      in_op = 2'b00;
      in_data = 32'h0000_00F0 + 32'(i);
      in_amt = 32'd3;
      in_tag = 4'(9 + i);
      @(posedge clk);
    end
    @(negedge clk);
    rst = 1'b1;
    #1;
    checks++;
    if (out_valid !== 1'b1) begin
      failures++; $display("FAIL rf_in_flight got=%b want=1", out_valid);
    end
    @(negedge clk);
    rst = 1'b0;
    in_valid = 1'b0;
    x_valid = 1'b0;
    out_ready = 1'b1;
    #1;
    checks++;
    if (out_valid !== 1'b0) begin
      failures++; $display("FAIL rf_out_valid got=%b want=0", out_valid);
    end
    checks++;
    if (out_data !== 32'h0) begin
      failures++; $display("FAIL rf_out_data got=%h want=0", out_data);
    end
    checks++;
    if (in_ready !== 1'b1) begin
      failures++; $display("FAIL rf_in_ready got=%b want=1", in_ready);
    end
    ghost = 1'b0;
    for (int c = 0; c < 8; c++) begin
      @(negedge clk);
      #1;
      if (out_valid || x1_out_valid || x5_out_valid) ghost = 1'b1;
    end
    checks++;
    if (ghost !== 1'b0) begin
      failures++; $display("FAIL rf_ghost got=%b want=0", ghost);
    end
  endtask

  initial begin
    test_reset();
    test_ops();
    test_back_to_back();
    test_stream();
    test_reset_flight();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
